fabric_mem_responder: RTL

Synthesizable responder tile for the core_rrv fabric protocol. It accepts WR/RD t_tile_trans requests addressed to its tile and holds a word-addressed local memory. For each RD it returns an RD_RSP transaction routed back to the requestor. It replaces the behavioural tile-33 memory model as the far end of OutFabric and drives the core's InFabric input.

---
 rtl/fabric_mem_responder_pkg.sv | 31 +++
 rtl/fabric_rsp_fifo.sv | 57 +++++
 rtl/fabric_mem_responder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/fabric_mem_responder_pkg.sv
// Shared fabric types for the responder tile: tile id, opcode, and the
// t_tile_trans transaction that carries requests and read responses.
// Also holds the helper that builds the RD_RSP return address.
package fabric_mem_responder_pkg;

  typedef logic [7:0] t_tile_id;

  // 2'd3 is reserved; the responder treats it like any other illegal opcode.
  typedef enum logic [1:0] {
    WR     = 2'd0,
    RD     = 2'd1,
    RD_RSP = 2'd2
  } t_opcode;

  typedef struct packed {
    t_opcode     opcode;
    logic [31:0] address;
    logic [31:0] data;
    t_tile_id    requestor_id;
    t_tile_id    next_tile_fifo_arb_id;
  } t_tile_trans;

  // Only the low 24 address bits travel back; the top byte names the
  // tile the response must be routed to.
  localparam int TILE_ADDR_W = 24;

  function automatic logic [31:0] rsp_address(t_tile_id rid, logic [TILE_ADDR_W-1:0] addr);
    return {rid, addr};
  endfunction

endpackage

// File: rtl/fabric_rsp_fifo.sv
// Generic synchronous FIFO used to queue read responses.
// Ports:
//   clk, rst_n          clock, async active-low reset (pointers/count only)
//   push, push_data     write side; a push while full is accepted only
//                       when a pop happens on the same edge
//   pop, pop_data       read side; pop_data is the current head
//   full, empty, count  occupancy status
module fabric_rsp_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 4,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  T            push_data,
  input  logic        pop,
  output T            pop_data,
  output logic        full,
  output logic        empty,
  output logic [PW:0] count
);

  T            mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic        do_push, do_pop;

  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // Push at full is legal when the head leaves on the same edge.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Storage is not reset; only the bookkeeping is.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fabric_mem_responder.sv
// Fabric memory responder tile. Accepts WR/RD requests, keeps a
// word-addressed local memory, and returns an RD_RSP for every RD.
// Ports:
//   Clock, RstN           clock, async active-low reset
//   local_tile_id         this tile's id, placed in RD_RSP.requestor_id
//   InReqValid/InReq/InReqReady     request handshake
//   OutRspValid/OutRsp/OutRspReady  response handshake (FIFO head)
//   WrCnt/RdCnt/DropCnt   saturating counts of accepted WR, RD, dropped
module fabric_mem_responder
  import fabric_mem_responder_pkg::*;
#(
  parameter int MEM_AW         = 10,
  parameter int RSP_FIFO_DEPTH = 4,
  parameter int CNT_W          = 16
) (
  input  logic             Clock,
  input  logic             RstN,
  input  t_tile_id         local_tile_id,
  input  logic             InReqValid,
  input  t_tile_trans      InReq,
  output logic             InReqReady,
  output logic             OutRspValid,
  output t_tile_trans      OutRsp,
  input  logic             OutRspReady,
  output logic [CNT_W-1:0] WrCnt,
  output logic [CNT_W-1:0] RdCnt,
  output logic [CNT_W-1:0] DropCnt
);

  localparam int CW = $clog2(RSP_FIFO_DEPTH);

  // ---------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------
  logic              ready_en;
  logic              acc, is_wr, is_rd, is_drop;
  logic [MEM_AW-1:0] word;

  assign acc     = InReqValid && InReqReady;
  assign is_wr   = acc && (InReq.opcode == WR);
  assign is_rd   = acc && (InReq.opcode == RD);
  assign is_drop = acc && !(InReq.opcode == WR) && !(InReq.opcode == RD);
  // Byte offset and address bits above the memory size are ignored, so
  // out-of-range addresses alias onto the array.
  assign word    = InReq.address[MEM_AW+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{InReq.address[31:TILE_ADDR_W], InReq.address[1:0]};

  // ---------------------------------------------------------------------
  // Flow control: credit covers both queued responses and the one in the
  // read stage, so the push one edge later always finds room.
  // ---------------------------------------------------------------------
  logic          rd_vld;
  logic [CW:0]   fifo_count;
  logic [CW+1:0] inflight;

  assign inflight   = (CW+2)'(fifo_count) + (CW+2)'(rd_vld);
  assign InReqReady = ready_en && (inflight < (CW+2)'(RSP_FIFO_DEPTH));

  // Holds ready low through reset and releases it on the first edge after.
  always_ff @(posedge Clock or negedge RstN) begin
    if (!RstN) ready_en <= 1'b0;
    else       ready_en <= 1'b1;
  end

  // ---------------------------------------------------------------------
  // Local memory (not reset, backdoor loadable) and read data register
  // ---------------------------------------------------------------------
  logic [31:0] mem [0:(1<<MEM_AW)-1];
  logic [31:0] rd_data;

  always_ff @(posedge Clock) begin
    if (is_wr) mem[word] <= InReq.data;
    if (is_rd) rd_data   <= mem[word];
  end

  // ---------------------------------------------------------------------
  // Read stage metadata; rd_vld is dropped by reset so in-flight reads
  // never reach the FIFO.
  // ---------------------------------------------------------------------
  logic [TILE_ADDR_W-1:0] rd_addr;
  t_tile_id               rd_rid;
  t_tile_id               rd_arb;

  always_ff @(posedge Clock or negedge RstN) begin
    if (!RstN) begin
      rd_vld  <= 1'b0;
      rd_addr <= '0;
      rd_rid  <= '0;
      rd_arb  <= '0;
    end else begin
      rd_vld <= is_rd;
      if (is_rd) begin
        rd_addr <= InReq.address[TILE_ADDR_W-1:0];
        rd_rid  <= InReq.requestor_id;
        rd_arb  <= InReq.next_tile_fifo_arb_id;
      end
    end
  end

  t_tile_trans rsp_in;

  always_comb begin
    rsp_in                       = '0;
    rsp_in.opcode                = RD_RSP;
    rsp_in.address               = rsp_address(rd_rid, rd_addr);
    rsp_in.data                  = rd_data;
    rsp_in.requestor_id          = local_tile_id;
    rsp_in.next_tile_fifo_arb_id = rd_arb;
  end

  // ---------------------------------------------------------------------
  // Response FIFO
  // ---------------------------------------------------------------------
  t_tile_trans rsp_head;
  logic        fifo_full, fifo_empty, rsp_pop;

  assign OutRspValid = !fifo_empty;
  assign rsp_pop     = OutRspValid && OutRspReady;
  // Head storage is unreset; drive zeros whenever nothing is presented.
  assign OutRsp      = OutRspValid ? rsp_head : '0;

  fabric_rsp_fifo #(
    .T     (t_tile_trans),
    .DEPTH (RSP_FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk       (Clock),
    .rst_n     (RstN),
    .push      (rd_vld),
    .push_data (rsp_in),
    .pop       (rsp_pop),
    .pop_data  (rsp_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Credit accounting must make an overflowing push impossible.
  a_no_overflow: assert property (@(posedge Clock) disable iff (!RstN)
    !(rd_vld && fifo_full && !rsp_pop));

  // ---------------------------------------------------------------------
  // Saturating statistics
  // ---------------------------------------------------------------------
  always_ff @(posedge Clock or negedge RstN) begin
    if (!RstN) begin
      WrCnt   <= '0;
      RdCnt   <= '0;
      DropCnt <= '0;
    end else begin
      if (is_wr   && !(&WrCnt))   WrCnt   <= WrCnt   + CNT_W'(1);
      if (is_rd   && !(&RdCnt))   RdCnt   <= RdCnt   + CNT_W'(1);
      if (is_drop && !(&DropCnt)) DropCnt <= DropCnt + CNT_W'(1);
    end
  end

endmodule
